// File: rtl/pl_mem_pkg.sv
// Shared constants for the memory-stage load/store unit: access-size encodings,
// FSM state encoding and datapath widths.
package pl_mem_pkg;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;
  localparam int F3_W   = 3;

  localparam logic [F3_W-1:0] F3_B  = 3'b000;
  localparam logic [F3_W-1:0] F3_H  = 3'b001;
  localparam logic [F3_W-1:0] F3_W_ = 3'b010;
  localparam logic [F3_W-1:0] F3_BU = 3'b100;
  localparam logic [F3_W-1:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/pl_lsu_align.sv
// Combinational lane logic: store replication/strobes, legality/alignment check,
// and load byte/halfword extraction with sign or zero extension.
module pl_lsu_align
  import pl_mem_pkg::*;
(
  input  logic [F3_W-1:0]   funct3,
  input  logic              is_write,
  input  logic [1:0]        addr_lo,
  input  logic [XLEN-1:0]   data,
  output logic [XLEN-1:0]   wdata,
  output logic [STRB_W-1:0] wstrb,
  output logic              misalign,
  input  logic [F3_W-1:0]   ld_funct3,
  input  logic [1:0]        ld_off,
  input  logic [XLEN-1:0]   rdata,
  output logic [XLEN-1:0]   ld_data
);

  logic       illegal;
  logic       unaligned;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    illegal = 1'b1;
    if (is_write) begin
      if (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W_) illegal = 1'b0;
    end else begin
      if (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W_ ||
          funct3 == F3_BU || funct3 == F3_HU) illegal = 1'b0;
    end
    unaligned = 1'b0;
    if ((funct3 == F3_H || funct3 == F3_HU) && addr_lo[0]) unaligned = 1'b1;
    if (funct3 == F3_W_ && addr_lo != 2'b00) unaligned = 1'b1;
    misalign = illegal | unaligned;
  end

  // Stores replicate the operand across all lanes; strobes pick the live bytes.
  always_comb begin
    wdata = data;
    wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      2'b01: begin
        wdata = {2{data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = data;
        wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    case (ld_off)
      2'd0:    ld_byte = rdata[7:0];
      2'd1:    ld_byte = rdata[15:8];
      2'd2:    ld_byte = rdata[23:16];
      default: ld_byte = rdata[31:24];
    endcase
    ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/pl_lsu_mem.sv
// Memory-stage load/store unit: issues one request per access on the
// request/ready bus, stalls the pipeline until done, and aborts on timeout.
module pl_lsu_mem
  import pl_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [F3_W-1:0]   funct3M,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              BusErrM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wstrb,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   rdata_q;
  logic [F3_W-1:0]   ld_f3_q;
  logic [1:0]        ld_off_q;

  logic              access;
  logic              bad;
  logic              start;
  logic              stall_raw;
  logic [XLEN-1:0]   al_wdata;
  logic [STRB_W-1:0] al_wstrb;
  logic [XLEN-1:0]   ld_data;

  assign access = MemReadM | MemWriteM;

  pl_lsu_align u_align (
    .funct3    (funct3M),
    .is_write  (MemWriteM),
    .addr_lo   (ALUResultM[1:0]),
    .data      (WriteDataM),
    .wdata     (al_wdata),
    .wstrb     (al_wstrb),
    .misalign  (bad),
    .ld_funct3 (ld_f3_q),
    .ld_off    (ld_off_q),
    .rdata     (mem_rdata),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    MisalignM = 1'b0;
    start     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (bad) begin
            MisalignM = 1'b1;
          end else begin
            start     = 1'b1;
            stall_raw = 1'b1;
            state_d   = REQ;
          end
        end
      end
      REQ: begin
        stall_raw = 1'b1;
        if (mem_ready || cnt_q == TO_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset must release the pipeline at once, even with an access still presented.
  assign StallM    = stall_raw & rst_n;
  assign ReadDataM = MisalignM ? '0 : rdata_q;

  // Bus outputs are latched at issue so they stay stable across wait states.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rdata_q   <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      BusErrM   <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
        mem_wdata <= al_wdata;
        mem_wstrb <= MemWriteM ? al_wstrb : '0;
        ld_f3_q   <= funct3M;
        ld_off_q  <= ALUResultM[1:0];
        cnt_q     <= '0;
      end else if (state_q == REQ) begin
        if (mem_ready) begin
          mem_req <= 1'b0;
          rdata_q <= mem_we ? '0 : ld_data;
        end else if (cnt_q == TO_LAST) begin
          mem_req <= 1'b0;
          BusErrM <= 1'b1;
          rdata_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pl_lsu_mem.sv
// Directed bench for pl_lsu_mem: drives accesses, models a wait-state responder
// with a small word memory, and checks bus activity and pipeline outputs.
module tb_pl_lsu_mem;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] memory [0:4095];

  int          resStall;
  int          resReq;
  logic        resDone;
  logic        resStable;
  logic [31:0] resData;
  logic        resBusErr;
  logic [31:0] resAddr;
  logic [31:0] resWdata;
  logic [3:0]  resWstrb;
  logic        resWe;
  logic        reqSeen;

  pl_lsu_mem #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "[TB] global time limit expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one access and runs it to its DONE cycle; inputs stay applied afterwards.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int waits, input logic noResp);
    resStall = 0; resReq = 0; resDone = 1'b0; resStable = 1'b1;
    resData = 'x; resBusErr = 1'bx;
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = addr; WriteDataM = data;
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !resDone; cyc++) begin
      #1;
      if (StallM) resStall++;
      if (mem_req) begin
        resReq++;
        if (resReq == 1) begin
          resAddr = mem_addr; resWdata = mem_wdata; resWstrb = mem_wstrb; resWe = mem_we;
        end else if (mem_addr !== resAddr || mem_wdata !== resWdata ||
                     mem_wstrb !== resWstrb || mem_we !== resWe) begin
          resStable = 1'b0;
        end
      end
      if (resStall > 0 && !StallM && !mem_req) begin
        resDone   = 1'b1;
        resData   = ReadDataM;
        resBusErr = BusErrM;
      end else begin
        if (mem_req && !noResp && resReq == waits + 1) begin
          mem_ready = 1'b1;
          if (mem_we) begin
            for (int b = 0; b < 4; b++)
              if (mem_wstrb[b]) memory[mem_addr[13:2]][b*8 +: 8] = mem_wdata[b*8 +: 8];
            mem_rdata = 32'hDEADBEEF;
          end else begin
            mem_rdata = memory[mem_addr[13:2]];
          end
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hDEADBEEF;
        end
        @(negedge clk);
      end
    end
    checkOutput("access_completed", {31'd0, resDone}, 32'd1);
  endtask

  task automatic idleBus();
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b0; mem_ready = 1'b0; mem_rdata = 32'hDEADBEEF;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) memory[i] = 32'd0;
    memory[32'h1000 >> 2] = 32'hA1B2C3D4;
    rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = 32'd0; WriteDataM = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
    #1;
    checkOutput("rst_mem_req", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_stall", {31'd0, StallM}, 32'd0);
    checkOutput("rst_readdata", ReadDataM, 32'd0);
    checkOutput("rst_buserr", {31'd0, BusErrM}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    $display("[TB] reset released");

    applyStimulus(1'b1, 1'b0, 3'b100, 32'h1003, 32'd0, 0, 1'b0);
    checkOutput("lbu_data", resData, 32'h000000A1);
    checkOutput("lbu_stall_cycles", resStall, 32'd2);
    checkOutput("lbu_req_cycles", resReq, 32'd1);
    checkOutput("lbu_bus_addr", resAddr, 32'h00001000);
    checkOutput("lbu_wstrb_read", {28'd0, resWstrb}, 32'd0);

    applyStimulus(1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 0, 1'b0);
    checkOutput("lb_data", resData, 32'hFFFFFFA1);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h1000, 32'd0, 0, 1'b0);
    checkOutput("lh_data", resData, 32'hFFFFC3D4);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h1002, 32'd0, 1, 1'b0);
    checkOutput("lhu_data", resData, 32'h0000A1B2);
    checkOutput("lhu_stall_cycles", resStall, 32'd3);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 0, 1'b0);
    checkOutput("lw_data", resData, 32'hA1B2C3D4);

    applyStimulus(1'b0, 1'b1, 3'b001, 32'h2002, 32'h0000BEEF, 3, 1'b0);
    checkOutput("sh_addr", resAddr, 32'h00002000);
    checkOutput("sh_wdata", resWdata, 32'hBEEFBEEF);
    checkOutput("sh_wstrb", {28'd0, resWstrb}, 32'h0000000C);
    checkOutput("sh_we", {31'd0, resWe}, 32'd1);
    checkOutput("sh_req_cycles", resReq, 32'd4);
    checkOutput("sh_stall_cycles", resStall, 32'd5);
    checkOutput("sh_bus_stable", {31'd0, resStable}, 32'd1);
    checkOutput("sh_readdata", resData, 32'd0);

    applyStimulus(1'b0, 1'b1, 3'b000, 32'h2001, 32'h1234565A, 0, 1'b0);
    checkOutput("sb_wdata", resWdata, 32'h5A5A5A5A);
    checkOutput("sb_wstrb", {28'd0, resWstrb}, 32'h00000002);
    checkOutput("sb_mem_word", memory[32'h2000 >> 2], 32'hBEEF5A00);

    // Misaligned/illegal accesses must not touch the bus and must zero ReadDataM.
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 0, 1'b0);
    @(negedge clk);
    MemReadM = 1'b1; MemWriteM = 1'b0; funct3M = 3'b010; ALUResultM = 32'h3001;
    #1;
    checkOutput("mis_lw_flag", {31'd0, MisalignM}, 32'd1);
    checkOutput("mis_lw_stall", {31'd0, StallM}, 32'd0);
    checkOutput("mis_lw_readdata", ReadDataM, 32'd0);
    reqSeen = mem_req;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      reqSeen = reqSeen | mem_req;
    end
    checkOutput("mis_lw_no_req", {31'd0, reqSeen}, 32'd0);
    funct3M = 3'b011; ALUResultM = 32'h3000;
    #1;
    checkOutput("ill_load_flag", {31'd0, MisalignM}, 32'd1);
    checkOutput("ill_load_stall", {31'd0, StallM}, 32'd0);
    MemReadM = 1'b0; MemWriteM = 1'b1; funct3M = 3'b100;
    #1;
    checkOutput("ill_store_flag", {31'd0, MisalignM}, 32'd1);
    @(negedge clk); #1;
    checkOutput("ill_no_req", {31'd0, mem_req}, 32'd0);
    idleBus();

    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 0, 1'b1);
    checkOutput("to_req_cycles", resReq, 32'd4);
    checkOutput("to_stall_cycles", resStall, 32'd5);
    checkOutput("to_buserr_done", {31'd0, resBusErr}, 32'd1);
    checkOutput("to_readdata", resData, 32'd0);
    idleBus();
    #1;
    checkOutput("to_buserr_cleared", {31'd0, BusErrM}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h1000, 32'd0, 0, 1'b0);
    checkOutput("to_recover_data", resData, 32'hFFFFFFD4);
    checkOutput("to_recover_buserr", {31'd0, resBusErr}, 32'd0);
    idleBus();

    @(negedge clk);
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h1000;
    @(negedge clk); #1;
    checkOutput("rst_mid_req_active", {31'd0, mem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req_drop", {31'd0, mem_req}, 32'd0);
    checkOutput("rst_mid_stall_drop", {31'd0, StallM}, 32'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h1000, 32'd0, 1, 1'b0);
    checkOutput("post_rst_lw", resData, 32'hA1B2C3D4);
    checkOutput("post_rst_req_cycles", resReq, 32'd2);

    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFEF00D, 0, 1'b0);
    checkOutput("b2b_sw_req", resReq, 32'd1);
    checkOutput("b2b_sw_wstrb", {28'd0, resWstrb}, 32'h0000000F);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'd0, 0, 1'b0);
    checkOutput("b2b_lw_data", resData, 32'hCAFEF00D);
    checkOutput("b2b_lw_req", resReq, 32'd1);
    checkOutput("b2b_lw_stall", resStall, 32'd2);
    idleBus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
